// File: rtl/sram_like_pkg.sv
// Shared types and constants for the SRAM-like responder and its request queue.
package sram_like_pkg;

  // sram_size encodings; 3 is treated as a word access.
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Queued request entry: {wr, size, wstrb, addr, wdata}.
  localparam int unsigned REQ_W = 1 + 2 + 4 + 32 + 32;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Service FSM for the queue head.
  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccess,
    StResp
  } state_e;

endpackage

// File: rtl/sram_like_req_fifo.sv
// In-order request queue holding accepted but not yet answered requests.
module sram_like_req_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 71
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;

  logic w_do_push;
  logic w_do_pop;

  // Pointers wrap explicitly so non-power-of-two depths also work.
  function automatic logic [PtrW-1:0] f_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_count == CntW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Entry storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= f_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= f_inc(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_responder.sv
// Responder end of the SRAM-like interface: queues requests in order and serves
// them one at a time from an on-chip word RAM after a programmable delay.
module sram_like_responder
  import sram_like_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2      = 12,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_req,
  input  logic        sram_wr,
  input  logic [1:0]  sram_size,
  input  logic [3:0]  sram_wstrb,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic        sram_addr_ok,
  output logic        sram_data_ok,
  output logic [31:0] sram_rdata,
  input  logic [3:0]  delay_cfg
);

  localparam int unsigned CntW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned Words = 1 << DEPTH_LOG2;

  logic [31:0]           r_mem [Words];
  logic [31:0]           r_rdata;
  state_e                r_state;
  state_e                w_state_nxt;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [CntW-1:0]       w_count;
  logic [REQ_W-1:0]      w_in;
  logic [REQ_W-1:0]      w_head_raw;
  req_t                  w_head;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_unused_ok;

  // Acceptance looks only at occupancy: no bypass from a same-cycle pop.
  assign sram_addr_ok = resetn & (w_count < CntW'(MAX_OUTSTANDING));
  assign w_push       = sram_req & sram_addr_ok;
  assign w_pop        = (r_state == StResp);
  assign w_in         = {sram_wr, sram_size, sram_wstrb, sram_addr, sram_wdata};
  assign w_head       = req_t'(w_head_raw);
  // Upper address bits alias; addr[1:0] never selects a word.
  assign w_idx        = w_head.addr[DEPTH_LOG2+1:2];

  assign sram_data_ok = (r_state == StResp);
  assign sram_rdata   = (r_state == StResp) ? r_rdata : 32'h0;

  // Size is carried for completeness; lane selection comes from wstrb alone.
  assign w_unused_ok  = ^{w_head.size, w_head.addr, w_full};

  sram_like_req_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (REQ_W)
  ) u_req_fifo (
    .i_clk   (clk),
    .i_rst_n (resetn),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_data  (w_head_raw),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Service FSM state and delay counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: delay is sampled when the head starts service.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_cnt_nxt   = delay_cfg;
          w_state_nxt = (delay_cfg != 4'd0) ? StWait : StAccess;
        end
      end
      StWait: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_state_nxt = StAccess;
        end
      end
      StAccess: w_state_nxt = StResp;
      StResp:   w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  // RAM write port with per-byte lane enables; contents survive reset.
  always_ff @(posedge clk) begin
    if ((r_state == StAccess) && w_head.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_head.wstrb[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_head.wdata[8*b +: 8];
        end
      end
    end
  end

  // Registered read data, presented during RESP; writes answer with zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdata <= 32'h0;
    end else if (r_state == StAccess) begin
      r_rdata <= w_head.wr ? 32'h0 : r_mem[w_idx];
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench for sram_like_responder: vector table plus queue-full and reset sequences.
module tb_sram_like_responder;

  logic        clk;
  logic        resetn;
  logic        sram_req;
  logic        sram_wr;
  logic [1:0]  sram_size;
  logic [3:0]  sram_wstrb;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_addr_ok;
  logic        sram_data_ok;
  logic [31:0] sram_rdata;
  logic [3:0]  delay_cfg;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  dly;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  sram_like_responder #(
    .DEPTH_LOG2      (12),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .sram_req     (sram_req),
    .sram_wr      (sram_wr),
    .sram_size    (sram_size),
    .sram_wstrb   (sram_wstrb),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_addr_ok (sram_addr_ok),
    .sram_data_ok (sram_data_ok),
    .sram_rdata   (sram_rdata),
    .delay_cfg    (delay_cfg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One request: wait for acceptance, measure accept-to-data_ok latency, check single pulse.
  task automatic do_req(input vec_t v, input string tag);
    int k;
    int extra;
    sram_wr    = v.wr;
    sram_size  = v.size;
    sram_wstrb = v.wstrb;
    sram_addr  = v.addr;
    sram_wdata = v.wdata;
    delay_cfg  = v.dly;
    sram_req   = 1'b1;
    k = 0;
    while (!sram_addr_ok && k < 20) begin
      step();
      k++;
    end
    check({tag, " accept"}, 32'(sram_addr_ok), 32'd1);
    step();
    sram_req = 1'b0;
    k = 1;
    while (!sram_data_ok && k < 40) begin
      step();
      k++;
    end
    check({tag, " latency"}, 32'(k), 32'(v.lat));
    check({tag, " rdata"}, sram_rdata, v.rdata);
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (sram_data_ok) extra++;
    end
    check({tag, " single_pulse"}, 32'(extra), 32'd0);
  endtask

  initial begin
    int acc[3];
    int n_acc;
    int dok;
    int cyc;
    int n_dok;
    logic [31:0] rd0;

    // wr size wstrb addr wdata dly exp_rdata exp_lat
    vecs[0]  = '{1'b1, 2'd2, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 4'd0,  32'h0000_0000, 3};
    vecs[1]  = '{1'b0, 2'd2, 4'h0, 32'h0000_0100, 32'h0,         4'd0,  32'hDEAD_BEEF, 3};
    vecs[2]  = '{1'b1, 2'd2, 4'hF, 32'h0000_0200, 32'h1122_3344, 4'd0,  32'h0000_0000, 3};
    vecs[3]  = '{1'b1, 2'd0, 4'h1, 32'h0000_0200, 32'h0000_00AA, 4'd0,  32'h0000_0000, 3};
    vecs[4]  = '{1'b0, 2'd2, 4'h0, 32'h0000_0200, 32'h0,         4'd0,  32'h1122_33AA, 3};
    vecs[5]  = '{1'b0, 2'd2, 4'h0, 32'h0000_0100, 32'h0,         4'd1,  32'hDEAD_BEEF, 4};
    vecs[6]  = '{1'b0, 2'd0, 4'h0, 32'h0000_0200, 32'h0,         4'd7,  32'h1122_33AA, 10};
    vecs[7]  = '{1'b0, 2'd1, 4'h0, 32'h0000_0100, 32'h0,         4'd15, 32'hDEAD_BEEF, 18};
    vecs[8]  = '{1'b1, 2'd2, 4'hF, 32'h0000_4000, 32'h5A5A_5A5A, 4'd0,  32'h0000_0000, 3};
    vecs[9]  = '{1'b0, 2'd2, 4'h0, 32'h0000_0000, 32'h0,         4'd0,  32'h5A5A_5A5A, 3};
    vecs[10] = '{1'b1, 2'd2, 4'hF, 32'h0000_0300, 32'h0102_0304, 4'd0,  32'h0000_0000, 3};
    vecs[11] = '{1'b1, 2'd2, 4'h0, 32'h0000_0300, 32'hFFFF_FFFF, 4'd2,  32'h0000_0000, 5};
    vecs[12] = '{1'b0, 2'd2, 4'h0, 32'h0000_0300, 32'h0,         4'd0,  32'h0102_0304, 3};
    vecs[13] = '{1'b1, 2'd1, 4'hC, 32'h0000_0302, 32'hCAFE_0000, 4'd0,  32'h0000_0000, 3};
    vecs[14] = '{1'b0, 2'd3, 4'h0, 32'h0000_0303, 32'h0,         4'd0,  32'hCAFE_0304, 3};

    resetn     = 1'b0;
    sram_req   = 1'b0;
    sram_wr    = 1'b0;
    sram_size  = 2'd0;
    sram_wstrb = 4'h0;
    sram_addr  = 32'h0;
    sram_wdata = 32'h0;
    delay_cfg  = 4'd0;
    step();
    step();
    check("reset addr_ok", 32'(sram_addr_ok), 32'd0);
    check("reset data_ok", 32'(sram_data_ok), 32'd0);
    check("reset rdata", sram_rdata, 32'h0);
    resetn = 1'b1;
    #1;
    check("post-reset addr_ok", 32'(sram_addr_ok), 32'd1);
    step();

    for (int i = 0; i < 15; i++) begin
      do_req(vecs[i], $sformatf("vec%0d", i));
    end

    // Queue full: three back-to-back reads held on req with delay 5.
    delay_cfg  = 4'd5;
    sram_wr    = 1'b0;
    sram_size  = 2'd2;
    sram_wstrb = 4'h0;
    sram_addr  = 32'h0000_0100;
    sram_req   = 1'b1;
    n_acc = 0;
    dok   = -1;
    cyc   = 0;
    rd0   = 32'h0;
    while (n_acc < 3 && cyc < 60) begin
      if (sram_addr_ok) begin
        acc[n_acc] = cyc;
        n_acc++;
      end
      if (sram_data_ok && dok < 0) begin
        dok = cyc;
        rd0 = sram_rdata;
      end
      step();
      cyc++;
    end
    sram_req = 1'b0;
    check("qfull accepts", 32'(n_acc), 32'd3);
    check("qfull acc0 cycle", 32'(acc[0]), 32'd0);
    check("qfull acc1 cycle", 32'(acc[1]), 32'd1);
    check("qfull first data_ok cycle", 32'(dok), 32'd8);
    check("qfull acc2 cycle", 32'(acc[2]), 32'd9);
    check("qfull first rdata", rd0, 32'hDEAD_BEEF);
    n_dok = 0;
    for (int i = 0; i < 40; i++) begin
      if (sram_data_ok) begin
        n_dok++;
        check($sformatf("qfull drain rdata %0d", n_dok), sram_rdata, 32'hDEAD_BEEF);
      end
      step();
    end
    check("qfull drain responses", 32'(n_dok), 32'd2);

    // Reset during WAIT drops both queued reads.
    delay_cfg = 4'd8;
    sram_addr = 32'h0000_0200;
    sram_req  = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 10 && n_acc < 2; i++) begin
      if (sram_addr_ok) n_acc++;
      step();
    end
    sram_req = 1'b0;
    check("rst accepts", 32'(n_acc), 32'd2);
    step();
    step();
    resetn = 1'b0;
    #1;
    check("rst addr_ok low", 32'(sram_addr_ok), 32'd0);
    check("rst data_ok low", 32'(sram_data_ok), 32'd0);
    step();
    resetn = 1'b1;
    #1;
    check("rst release addr_ok", 32'(sram_addr_ok), 32'd1);
    n_dok = 0;
    for (int i = 0; i < 30; i++) begin
      if (sram_data_ok) n_dok++;
      step();
    end
    check("rst dropped responses", 32'(n_dok), 32'd0);
    do_req(vecs[4], "after_rst byte");
    do_req(vecs[1], "after_rst word");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
